minibus_arbiter: RTL
====================

Name: minibus_arbiter

Overview:
- Round-robin arbiter that shares one minibus slave port (e.g. a minibus_slave_regs instance) between N_MASTERS requesters.
- Grants one master at a time and holds the grant until the transaction completes: slave ack, slave err, master abort, or timeout.
- After every transaction it inserts one idle cycle on the slave side, so the slave's registered ready/err flags clear before the next master is granted.
- Sits between the core/DMA master ports and a peripheral slave.

Parameters:
- N_MASTERS, 2, number of requesting masters (≥2).
- TIMEOUT_CYCLES, 16, BUSY cycles without a slave response before an error is returned; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- m_sel  in  N_MASTERS  per-master request; held until that master sees ack/err
- m_wen, m_ren  in  N_MASTERS each  per-master write/read enables
- m_addr  in  [N_MASTERS-1:0][ADDR_WIDTH-1:0]  per-master byte address
- m_width  in  [N_MASTERS-1:0][1:0]  per-master access width (00 byte, 01 half, 10 word)
- m_wdata  in  [N_MASTERS-1:0][DATA_WIDTH-1:0]  per-master write data
- m_ack, m_err  out  N_MASTERS each  per-master response strobes
- m_rdata  out  DATA_WIDTH  read data, shared by all masters; valid with m_ack
- s_sel, s_wen, s_ren  out  1 each  slave-side request
- s_addr  out  ADDR_WIDTH  slave-side address
- s_width  out  2  slave-side width
- s_wdata  out  DATA_WIDTH  slave-side write data
- s_ack, s_err  in  1 each  slave response
- s_rdata  in  DATA_WIDTH  slave read data
- grant_id  out  $clog2(N_MASTERS)  index of the current/last granted master
- busy  out  1  high in BUSY

Behaviour:
- States: IDLE, BUSY, GAP. Reset (rst=1 at a clk edge): state=IDLE, grant_id=0, last_grant=N_MASTERS-1, timeout counter=0.
- Arbitration, in IDLE and GAP: search m_sel starting at last_grant+1, wrapping modulo N_MASTERS. The first set bit g is registered: grant_id<=g, last_grant<=g, state<=BUSY. If no m_sel bit is set: IDLE stays IDLE, GAP goes to IDLE.
- s_* outputs are combinational:
  - BUSY: s_sel=m_sel[grant_id]; s_wen, s_ren, s_addr, s_width and s_wdata are taken from master grant_id.
  - IDLE and GAP: all s_* outputs are 0.
- Responses are combinational in BUSY only:
  - m_ack[grant_id]=s_ack; m_err[grant_id]=s_err.
  - All other m_ack/m_err bits are 0; all are 0 outside BUSY.
  - m_rdata=s_rdata at all times.
- BUSY exits, all to GAP, priority top-down:
  - s_ack or s_err: response forwarded this cycle.
  - m_sel[grant_id]=0 (abort): no response; s_sel drops in the same cycle.
  - Timeout: counter reaches TIMEOUT_CYCLES-1 with no response (TIMEOUT_CYCLES≠0). m_err[grant_id] pulses for that cycle and s_sel stays asserted through it.
- Timeout counter: cleared on BUSY entry, incremented each BUSY cycle, saturates.
- Latency with a 1-cycle slave, request first seen in IDLE at cycle 0: BUSY at c1, m_ack at c2, GAP at c3, next grant BUSY at c4. Back-to-back transaction period is 3 cycles.
- GAP is never skipped, including after an abort or a timeout.
- s_ack/s_err arriving in IDLE or GAP are ignored (dropped).
- s_ack and s_err asserted together: both forwarded.
- rst asserted mid-BUSY: next state IDLE, s_sel=0 in the following cycle, no response is issued.
- grant_id holds its value in IDLE and GAP.

Decomposition:
- ADDR_WIDTH, DATA_WIDTH and the width encodings already live in minibus_pkg.
- Add to minibus_pkg: typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_GAP} minibus_arb_state_t.
- One sub-module: minibus_rr_picker, parameterised N; inputs req and last; outputs idx and valid; purely combinational round-robin search.
- FSM and mux stay in the top module.

Test Plan:
1. Single master: after reset, m_sel[0]=1, word write addr 0x4, wdata 0xDEADBEEF, slave acks 1 cycle after s_sel. Required: s_sel high c1–c2 only; m_ack[0] at c2; busy low at c3; a following read of addr 0x4 returns m_rdata=0xDEADBEEF.
2. Contention: m_sel=2'b11 held continuously, both masters re-requesting immediately after ack. Required: grants alternate 0,1,0,1; each grant starts 3 cycles after the previous one; s_sel low for exactly 1 cycle between grants; m_ack never asserted for the non-granted master.
3. Stale ack: slave model that keeps ack high for 2 cycles. Required: the second ack falls in GAP, is dropped, and is never forwarded to the next granted master.
4. Timeout: TIMEOUT_CYCLES=4, slave never acks. Required: m_err[grant_id] asserted exactly 4 cycles after BUSY entry, then GAP, then the next requester is granted.
5. Abort: master 1 drops m_sel at the first BUSY cycle. Required: s_sel=0 in that same cycle; no m_ack/m_err to master 1; FSM passes through GAP.
6. Reset mid-transaction: rst=1 while BUSY. Required: next cycle state=IDLE, s_sel=0, grant_id=0; with m_sel=2'b11 afterwards, master 0 is granted first.

Source files
------------

// File: rtl/minibus_pkg.sv
// Shared minibus definitions: bus widths, access-width encodings and the
// arbiter state type used by minibus_arbiter.
package minibus_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] MB_WIDTH_BYTE = 2'b00;
    localparam logic [1:0] MB_WIDTH_HALF = 2'b01;
    localparam logic [1:0] MB_WIDTH_WORD = 2'b10;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_GAP
    } minibus_arb_state_t;

endpackage

// File: rtl/minibus_rr_picker.sv
// Combinational round-robin search: returns the first set request bit found
// after position 'last', wrapping modulo N.
module minibus_rr_picker #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) begin
                idx   = IW'((int'(last) + k) % N);
                valid = 1'b1;
            end else begin
                idx   = idx;
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/minibus_arbiter.sv
// Round-robin arbiter sharing one minibus slave among N_MASTERS masters; holds
// the grant for a whole transaction and inserts one idle slave cycle after it.
module minibus_arbiter
    import minibus_pkg::*;
#(
    parameter int N_MASTERS      = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_MASTERS-1:0]                  m_sel,
    input  logic [N_MASTERS-1:0]                  m_wen,
    input  logic [N_MASTERS-1:0]                  m_ren,
    input  logic [N_MASTERS-1:0][ADDR_WIDTH-1:0]  m_addr,
    input  logic [N_MASTERS-1:0][1:0]             m_width,
    input  logic [N_MASTERS-1:0][DATA_WIDTH-1:0]  m_wdata,
    output logic [N_MASTERS-1:0]                  m_ack,
    output logic [N_MASTERS-1:0]                  m_err,
    output logic [DATA_WIDTH-1:0]                 m_rdata,
    output logic                                  s_sel,
    output logic                                  s_wen,
    output logic                                  s_ren,
    output logic [ADDR_WIDTH-1:0]                 s_addr,
    output logic [1:0]                            s_width,
    output logic [DATA_WIDTH-1:0]                 s_wdata,
    input  logic                                  s_ack,
    input  logic                                  s_err,
    input  logic [DATA_WIDTH-1:0]                 s_rdata,
    output logic [$clog2(N_MASTERS)-1:0]          grant_id,
    output logic                                  busy
);

    localparam int IW = $clog2(N_MASTERS);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    minibus_arb_state_t r_state, w_state_next;
    logic [IW-1:0]      r_grant, w_grant_next;
    logic [IW-1:0]      r_last, w_last_next;
    logic [CW-1:0]      r_tcnt, w_tcnt_next;
    logic [IW-1:0]      w_pick_idx;
    logic               w_pick_valid;
    logic               w_gsel;
    logic               w_timeout;

    minibus_rr_picker #(.N(N_MASTERS)) u_picker (
        .req   (m_sel),
        .last  (r_last),
        .idx   (w_pick_idx),
        .valid (w_pick_valid)
    );

    assign w_gsel    = m_sel[r_grant];
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_tcnt == TO_LAST);
    assign m_rdata   = s_rdata;
    assign grant_id  = r_grant;
    assign busy      = (r_state == ARB_BUSY);

    // State, grant and timeout registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_last  <= IW'(N_MASTERS - 1);
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_last  <= w_last_next;
            r_tcnt  <= w_tcnt_next;
        end
    end

    // Next-state logic, slave-side mux and response routing.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_last_next  = r_last;
        w_tcnt_next  = r_tcnt;
        s_sel        = 1'b0;
        s_wen        = 1'b0;
        s_ren        = 1'b0;
        s_addr       = '0;
        s_width      = 2'b00;
        s_wdata      = '0;
        m_ack        = '0;
        m_err        = '0;
        case (r_state)
            ARB_IDLE, ARB_GAP: begin
                if (w_pick_valid) begin
                    w_state_next = ARB_BUSY;
                    w_grant_next = w_pick_idx;
                    w_last_next  = w_pick_idx;
                    w_tcnt_next  = '0;
                end else begin
                    w_state_next = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                s_sel            = w_gsel;
                s_wen            = m_wen[r_grant];
                s_ren            = m_ren[r_grant];
                s_addr           = m_addr[r_grant];
                s_width          = m_width[r_grant];
                s_wdata          = m_wdata[r_grant];
                m_ack[r_grant]   = s_ack;
                // A real response or an abort takes precedence over the timeout error.
                m_err[r_grant]   = s_err | (w_timeout & w_gsel & ~s_ack);
                if (r_tcnt != '1) begin
                    w_tcnt_next = r_tcnt + CW'(1);
                end else begin
                    w_tcnt_next = r_tcnt;
                end
                if (s_ack || s_err || !w_gsel || w_timeout) begin
                    w_state_next = ARB_GAP;
                end else begin
                    w_state_next = ARB_BUSY;
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

endmodule
